uart_tx_frame: RTL

//  UART transmitter: the transmit-side counterpart of the Uart_Rx path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/tx_bit_timer.sv | 35 +++
 rtl/uart_tx_frame.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// This file holds the frame FSM states, the parity-type encodings and the lowest usable bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Values of PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any Prescale below this value is raised to it when the word is accepted.
  localparam int MIN_PRESCALE = 5;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timer for the UART transmitter.
// edge_count holds the cycle position inside the current bit and counts 1..ps.
// bit_idx holds the position of the bit inside the frame: 0 is the start bit and data bit k is k+1.
// Both counters return to zero whenever counting is disabled.
module tx_bit_timer #(
  parameter int PRESCALE_W = 5,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_en,
  input  logic [PRESCALE_W-1:0] ps,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  last_edge
);

  // A count of zero means the counter is idle. That zero never matches a bit period,
  // even when ps is still cleared after reset.
  assign last_edge = (edge_count != '0) && (edge_count == ps);

  // Count cycles inside a bit, and move to the next bit position after the final cycle.
  always_ff @(posedge clk) begin
    if (reset || !count_en) begin
      edge_count <= '0;
      bit_idx    <= '0;
    end else if (last_edge) begin
      edge_count <= PRESCALE_W'(1);
      bit_idx    <= bit_idx + IDX_W'(1);
    end else begin
      edge_count <= edge_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter.
// The block takes one parallel word and sends it LSB first. The frame is a start bit,
// the data bits, an optional parity bit and a stop bit. Each bit lasts Prescale cycles.
// TX_OUT and Busy come straight from registers, so the serial line cannot glitch.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 5
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 3);
  localparam int SEL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] MIN_PS = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_WIDTH);

  tx_state_t state, next_state;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] ps_q;

  logic                  accept;
  logic                  count_en;
  logic                  tx_next;
  logic                  busy_next;
  logic                  parity_bit;
  logic [IDX_W-1:0]      next_idx;
  logic [IDX_W-1:0]      data_sel;

  logic [PRESCALE_W-1:0] edge_count_unused;
  logic [IDX_W-1:0]      bit_idx;
  logic                  last_edge;

  assign accept     = (state == IDLE) && !Busy && Data_Valid;
  assign parity_bit = (par_typ_q == PAR_ODD) ? ~^data_q : ^data_q;

  tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (CLK),
    .reset      (Reset),
    .count_en   (count_en),
    .ps         (ps_q),
    .edge_count (edge_count_unused),
    .bit_idx    (bit_idx),
    .last_edge  (last_edge)
  );

  // Capture the word and its frame settings when the word is accepted. They stay fixed until the frame ends.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ps_q      <= '0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      ps_q      <= (Prescale < MIN_PS) ? MIN_PS : Prescale;
    end
  end

  // State register. The serial line and Busy are registered here as well.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= tx_next;
      Busy   <= busy_next;
    end
  end

  // Frame sequencing. Each non-idle state ends on the final cycle of its bit period.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   if (last_edge) next_state = DATA;
      DATA:    if (last_edge && (bit_idx == LAST_DATA_IDX))
                 next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) next_state = STOP;
      STOP:    if (last_edge) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Work out the line level for the next cycle from the state and bit position that take effect on that edge.
  always_comb begin
    count_en  = (next_state != IDLE);
    busy_next = (next_state != IDLE);
    next_idx  = last_edge ? (bit_idx + IDX_W'(1)) : bit_idx;
    data_sel  = next_idx - IDX_W'(1);
    tx_next   = 1'b1;
    case (next_state)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[data_sel[SEL_W-1:0]];
      PARITY:  tx_next = parity_bit;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
